// File: rtl/mic1_sequencer.sv
// -----------------------------------------------------------------------------
// mic1_sequencer
//
// Microprogram sequencer for a MIC-1 style datapath. Each microinstruction is
// fetched from an external synchronous control store, held in the MIR, and
// its datapath fields are presented during EXEC. The next microprogram
// address is formed in NEXT from NEXT_ADDRESS, the JAMN/JAMZ flag jams and
// the JMPC MBR dispatch. There is no implicit increment.
//
// MIR layout:
//   [35:27] NEXT_ADDRESS  [26] JMPC  [25] JAMN  [24] JAMZ
//   [23:16] ALU           [15:7] C   [6:4] MEM  [3:0] B
//
// Ports:
//   clk        in   1       sole clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   run        in   1       start/continue sequencing (sampled in IDLE/NEXT)
//   stall      in   1       memory wait, extends EXEC
//   cs_addr    out  ADDR_W  control-store read address (always mpc)
//   cs_rd      out  1       control-store read strobe (FETCH only)
//   cs_rdata   in   MIR_W   control-store data, valid the cycle after cs_rd
//   mbr        in   8       MBR byte for JMPC dispatch
//   alu_n      in   1       ALU N flag
//   alu_z      in   1       ALU Z flag
//   alu_ctl    out  8       {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}
//   c_sel      out  9       C-bus write enables
//   mem_op     out  3       {WRITE,READ,FETCH}
//   b_sel      out  4       B-bus source select
//   exec_valid out  1       datapath controls are valid this cycle
//   mpc        out  ADDR_W  current microprogram counter
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for run; no control-store access, outputs quiet
// FETCH | cs_rd asserted with cs_addr = mpc
// LOAD  | control-store data arrives; captured into MIR at end of cycle
// EXEC  | datapath fields driven; held while stall=1; flags latched on exit
// NEXT  | mpc loaded from NEXT_ADDRESS / jams / dispatch; run re-sampled
// -----------------------------------------------------------------------------
module mic1_sequencer #(
    parameter int ADDR_W = 9,
    parameter int MIR_W  = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              stall,
    output logic [ADDR_W-1:0] cs_addr,
    output logic              cs_rd,
    input  logic [MIR_W-1:0]  cs_rdata,
    input  logic [7:0]        mbr,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic [7:0]        alu_ctl,
    output logic [8:0]        c_sel,
    output logic [2:0]        mem_op,
    output logic [3:0]        b_sel,
    output logic              exec_valid,
    output logic [ADDR_W-1:0] mpc
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;

    localparam int NA_HI   = 35;
    localparam int NA_LO   = 27;
    localparam int JMPC_B  = 26;
    localparam int JAMN_B  = 25;
    localparam int JAMZ_B  = 24;
    localparam int ALU_HI  = 23;
    localparam int ALU_LO  = 16;
    localparam int C_HI    = 15;
    localparam int C_LO    = 7;
    localparam int MEM_HI  = 6;
    localparam int MEM_LO  = 4;
    localparam int B_HI    = 3;
    localparam int B_LO    = 0;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [MIR_W-1:0]  mir;
    logic              n_flag;
    logic              z_flag;
    logic [ADDR_W-1:0] mpc_nxt;

    logic [8:0]        next_address;
    logic              jam_hi;
    logic [7:0]        addr_lo;

    // ------------------------------------------------------------------
    // State register and transitions
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = stall ? ST_EXEC : ST_NEXT;
            ST_NEXT:  state_nxt = run ? ST_FETCH : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // MIR: captured only as LOAD ends, when the control-store data is valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mir <= '0;
        end else if (state == ST_LOAD) begin
            mir <= cs_rdata;
        end
    end

    // ------------------------------------------------------------------
    // N/Z flags: sampled on the cycle that leaves EXEC, so values seen
    // during memory-wait cycles never reach the branch logic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if ((state == ST_EXEC) && !stall) begin
            n_flag <= alu_n;
            z_flag <= alu_z;
        end
    end

    // ------------------------------------------------------------------
    // Next-address formation. The jams and the MBR dispatch are ORed onto
    // NEXT_ADDRESS; nothing is added, so 9'h1FF simply goes wherever the
    // fields point.
    // ------------------------------------------------------------------
    always_comb begin
        next_address = mir[NA_HI:NA_LO];
        jam_hi       = next_address[8]
                     | (mir[JAMN_B] & n_flag)
                     | (mir[JAMZ_B] & z_flag);
        addr_lo      = next_address[7:0] | (mir[JMPC_B] ? mbr : 8'h00);
        mpc_nxt      = {jam_hi, addr_lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpc <= '0;
        end else if (state == ST_NEXT) begin
            mpc <= mpc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Decoded from the state register so reset quiets them at once.
    // ------------------------------------------------------------------
    always_comb begin
        cs_addr    = mpc;
        cs_rd      = (state == ST_FETCH);
        exec_valid = 1'b0;
        alu_ctl    = 8'h00;
        c_sel      = 9'h000;
        mem_op     = 3'b000;
        b_sel      = 4'h0;
        if (state == ST_EXEC) begin
            exec_valid = 1'b1;
            alu_ctl    = mir[ALU_HI:ALU_LO];
            c_sel      = mir[C_HI:C_LO];
            mem_op     = mir[MEM_HI:MEM_LO];
            b_sel      = mir[B_HI:B_LO];
        end
    end

endmodule

// File: tb/tb_mic1_sequencer.sv
module tb_mic1_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        stall;
    logic [8:0]  cs_addr;
    logic        cs_rd;
    logic [35:0] cs_rdata;
    logic [7:0]  mbr;
    logic        alu_n;
    logic        alu_z;
    logic [7:0]  alu_ctl;
    logic [8:0]  c_sel;
    logic [2:0]  mem_op;
    logic [3:0]  b_sel;
    logic        exec_valid;
    logic [8:0]  mpc;

    int checks = 0;
    int errors = 0;

    // Control-store model: synchronous read, data valid the cycle after cs_rd.
    logic [35:0] rom [512];

    // Behavioural reference state: program counter and the latched flags.
    logic [8:0]  exp_mpc;
    logic        m_n;
    logic        m_z;

    mic1_sequencer #(.ADDR_W(9), .MIR_W(36)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .stall      (stall),
        .cs_addr    (cs_addr),
        .cs_rd      (cs_rd),
        .cs_rdata   (cs_rdata),
        .mbr        (mbr),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_ctl    (alu_ctl),
        .c_sel      (c_sel),
        .mem_op     (mem_op),
        .b_sel      (b_sel),
        .exec_valid (exec_valid),
        .mpc        (mpc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (cs_rd) cs_rdata <= rom[cs_addr];
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic [8:0] na, input logic jmpc, input logic jamn,
                                       input logic jamz, input logic [7:0] alu, input logic [8:0] c,
                                       input logic [2:0] mem, input logic [3:0] b);
        return {na, jmpc, jamn, jamz, alu, c, mem, b};
    endfunction

    // Reference next-address rule, written from the field definitions.
    function automatic logic [8:0] ref_next(input logic [35:0] w, input logic [7:0] mbr_v,
                                            input logic n, input logic z);
        logic [8:0] na;
        logic       hi;
        logic [7:0] lo;
        na = w[35:27];
        hi = na[8] | (w[25] & n) | (w[24] & z);
        lo = na[7:0] | (w[26] ? mbr_v : 8'h00);
        return {hi, lo};
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_ev"},  36'(exec_valid), 36'd0);
        chk({tag, "_dp"},  36'({alu_ctl, c_sel, mem_op, b_sel}), 36'd0);
    endtask

    // Runs one microinstruction starting at the negedge inside FETCH.
    // k = number of stall cycles; fn/fz = flags presented on the final EXEC cycle.
    task automatic do_instr(input logic [35:0] w, input int k, input logic fn, input logic fz,
                            input logic [7:0] mbr_v, input logic run_after);
        rom[exp_mpc] = w;
        chk("fetch_rd",   36'(cs_rd),      36'd1);
        chk("fetch_addr", 36'(cs_addr),    36'(exp_mpc));
        chk("fetch_mpc",  36'(mpc),        36'(exp_mpc));
        check_quiet("fetch");
        stall = 1'($urandom_range(0, 1));
        run   = 1'($urandom_range(0, 1));
        mbr   = mbr_v;
        @(negedge clk);
        chk("load_rd", 36'(cs_rd), 36'd0);
        check_quiet("load");
        stall = 1'($urandom_range(0, 1));
        for (int e = 0; e <= k; e++) begin
            @(negedge clk);
            chk("exec_ev", 36'(exec_valid), 36'd1);
            chk("exec_rd", 36'(cs_rd), 36'd0);
            chk("exec_fields", 36'({alu_ctl, c_sel, mem_op, b_sel}), 36'(w[23:0]));
            if (e < k) begin
                stall = 1'b1;
                alu_n = 1'($urandom_range(0, 1));
                alu_z = ~alu_z;
            end else begin
                stall = 1'b0;
                alu_n = fn;
                alu_z = fz;
            end
            run = 1'($urandom_range(0, 1));
        end
        m_n = fn;
        m_z = fz;
        @(negedge clk);
        chk("next_rd", 36'(cs_rd), 36'd0);
        check_quiet("next");
        chk("next_mpc_hold", 36'(mpc), 36'(exp_mpc));
        exp_mpc = ref_next(w, mbr_v, m_n, m_z);
        stall = 1'($urandom_range(0, 1));
        alu_n = 1'($urandom_range(0, 1));
        alu_z = 1'($urandom_range(0, 1));
        run   = run_after;
        @(negedge clk);
        chk("mpc_after", 36'(mpc), 36'(exp_mpc));
        if (run_after) chk("refetch_on_time", 36'(cs_rd), 36'd1);
        else           chk("idle_rd", 36'(cs_rd), 36'd0);
    endtask

    // Sits in IDLE for n cycles, then restarts; returns at the FETCH negedge.
    task automatic idle_resume(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_rd", 36'(cs_rd), 36'd0);
            chk("idle_mpc", 36'(mpc), 36'(exp_mpc));
            check_quiet("idle");
            run   = 1'b0;
            stall = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        run = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd"},   36'(cs_rd),   36'd0);
        chk({tag, "_addr"}, 36'(cs_addr), 36'd0);
        chk({tag, "_mpc"},  36'(mpc),     36'd0);
        check_quiet(tag);
    endtask

    initial begin
        logic [35:0] w;
        logic [7:0]  mb;
        int          k;
        logic        ra;

        for (int i = 0; i < 512; i++) rom[i] = 36'h0;
        rst_n = 1'b0; run = 1'b1; stall = 1'b0; mbr = 8'h00;
        alu_n = 1'b0; alu_z = 1'b0;
        exp_mpc = 9'h000; m_n = 1'b0; m_z = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain sequencing: fetch 0, ALU 3C in EXEC, next fetch at 5
        do_instr(mk(9'h005, 0, 0, 0, 8'h3C, 9'h000, 3'b000, 4'h0), 0, 0, 0, 8'h00, 1);
        // JAMZ taken, then not taken
        do_instr(mk(9'h010, 0, 0, 1, 8'h11, 9'h101, 3'b010, 4'h3), 0, 0, 1, 8'h00, 1);
        chk("jamz_taken", 36'(mpc), 36'h110);
        do_instr(mk(9'h010, 0, 0, 1, 8'h22, 9'h0F0, 3'b001, 4'h5), 0, 1, 0, 8'h00, 1);
        chk("jamz_not_taken", 36'(mpc), 36'h010);
        // JAMN and JAMZ together are ORed, not added
        do_instr(mk(9'h020, 0, 1, 1, 8'h44, 9'h1FF, 3'b100, 4'h8), 0, 1, 1, 8'h00, 1);
        chk("jamn_jamz_or", 36'(mpc), 36'h120);
        // JMPC dispatch
        do_instr(mk(9'h100, 1, 0, 0, 8'h88, 9'h003, 3'b000, 4'hA), 0, 0, 0, 8'h59, 1);
        chk("jmpc_dispatch", 36'(mpc), 36'h159);
        // Stall of 3 cycles with toggling Z; final Z=1 steers the jam
        do_instr(mk(9'h030, 0, 0, 1, 8'hC3, 9'h155, 3'b111, 4'hF), 3, 0, 1, 8'h00, 0);
        chk("stall_z_latched", 36'(mpc), 36'h130);
        idle_resume(3);
        // Jump to 1FF, then from 1FF: no increment, bit8 of NEXT kept under JMPC
        do_instr(mk(9'h1FF, 0, 0, 0, 8'h01, 9'h001, 3'b001, 4'h1), 1, 1, 1, 8'h00, 1);
        do_instr(mk(9'h1A0, 1, 0, 0, 8'h02, 9'h002, 3'b010, 4'h2), 0, 0, 0, 8'h0F, 1);
        chk("jmpc_keeps_bit8", 36'(mpc), 36'h1AF);

        // Reset in the middle of EXEC
        rom[exp_mpc] = mk(9'h077, 0, 1, 1, 8'hFF, 9'h1FF, 3'b111, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_exec", 36'(exec_valid), 36'd1);
        stall = 1'b0; alu_n = 1'b1; alu_z = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_exec");
        exp_mpc = 9'h000; m_n = 1'b0; m_z = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst_n = 1'b1; run = 1'b1;
        @(negedge clk);
        do_instr(mk(9'h040, 0, 0, 1, 8'h5A, 9'h0A5, 3'b010, 4'h6), 0, 0, 0, 8'h00, 1);
        chk("post_reset_path", 36'(mpc), 36'h040);

        // Randomized microprograms against the reference model
        for (int n = 0; n < 40; n++) begin
            w[31:0]  = $urandom;
            w[35:32] = 4'($urandom_range(0, 15));
            mb = 8'($urandom_range(0, 255));
            k  = $urandom_range(0, 3);
            ra = ($urandom_range(0, 5) != 0);
            do_instr(w, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mb, ra);
            if (!ra) idle_resume($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
